// File: rtl/snake_body_engine.sv
// Per-player snake body engine: segment list, move/grow/collision handling and
// a registered per-pixel cell classifier feeding the display's sprite ROM.

module snake_seg_cmp (
  input  logic [5:0] i_sx,
  input  logic [4:0] i_sy,
  input  logic       i_pix_vld,
  input  logic       i_chk_vld,
  input  logic [5:0] i_px,
  input  logic [5:0] i_py,
  input  logic [5:0] i_nx,
  input  logic [4:0] i_ny,
  output logic       o_pix_hit,
  output logic       o_chk_hit
);
  assign o_pix_hit = i_pix_vld && (i_sx == i_px) && ({1'b0, i_sy} == i_py);
  assign o_chk_hit = i_chk_vld && (i_sx == i_nx) && (i_sy == i_ny);
endmodule

module snake_body_engine #(
  parameter int         MAX_LEN  = 16,
  parameter int         INIT_LEN = 3,
  parameter int         INIT_X   = 10,
  parameter int         INIT_Y   = 10,
  parameter logic [1:0] INIT_DIR = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_game_status,
  input  logic       i_move_tick,
  input  logic [1:0] i_dir_in,
  input  logic       i_grow,
  input  logic [9:0] i_pos_x,
  input  logic [9:0] i_pos_y,
  output logic [1:0] o_snake_show,
  output logic [3:0] o_snake_image,
  output logic [5:0] o_head_x,
  output logic [4:0] o_head_y,
  output logic [4:0] o_length,
  output logic       o_hit_wall,
  output logic       o_hit_self
);
  typedef enum logic [1:0] {S_INIT, S_HOLD, S_RUN} state_t;

  function automatic logic [MAX_LEN-1:0][5:0] f_init_x();
    logic [MAX_LEN-1:0][5:0] v;
    for (int i = 0; i < MAX_LEN; i++) v[i] = (i < INIT_LEN) ? 6'(INIT_X - i) : 6'd0;
    return v;
  endfunction

  localparam logic [MAX_LEN-1:0][5:0] L_INIT_X = f_init_x();
  localparam logic [MAX_LEN-1:0][4:0] L_INIT_Y = {MAX_LEN{5'(INIT_Y)}};
  localparam logic [MAX_LEN-1:0][1:0] L_INIT_D = {MAX_LEN{INIT_DIR}};

  logic [MAX_LEN-1:0][5:0] r_seg_x;
  logic [MAX_LEN-1:0][4:0] r_seg_y;
  logic [MAX_LEN-1:0][1:0] r_seg_dir;
  logic [4:0]  r_len;
  logic [1:0]  r_cur_dir;
  logic        r_grow_pend, r_hit_wall, r_hit_self;
  logic [1:0]  r_show;
  logic [3:0]  r_img;

  state_t      w_state;
  logic        w_do_init, w_do_move;
  logic [1:0]  w_dir;
  logic [5:0]  w_nx;
  logic [4:0]  w_ny;
  logic        w_gp, w_nh_wall, w_nh_self;
  logic [4:0]  w_chk_len;
  logic [5:0]  w_cx, w_cy;
  logic        w_pix_wall, w_body_hit;
  logic [4:0]  w_body_idx;
  logic [1:0]  w_body_dir;
  logic [MAX_LEN-1:0] w_pix_hit, w_chk_hit;
  logic        w_unused_bits;

  // Mode follows game_status combinationally; a set collision flag parks the snake.
  always_comb begin
    w_state = S_HOLD;
    if (i_game_status == 2'b00) w_state = S_INIT;
    else if (i_game_status == 2'b10 && !r_hit_wall && !r_hit_self) w_state = S_RUN;
  end

  always_comb begin
    w_do_init = (w_state == S_INIT);
    w_do_move = (w_state == S_RUN) && i_move_tick;
  end

  // Reversal: same axis (dir[1]) but a different heading.
  assign w_dir = ((i_dir_in[1] == r_cur_dir[1]) && (i_dir_in != r_cur_dir)) ? r_cur_dir : i_dir_in;

  always_comb begin
    w_nx = r_seg_x[0];
    w_ny = r_seg_y[0];
    case (w_dir)
      2'd0:    w_ny = r_seg_y[0] - 5'd1;
      2'd1:    w_ny = r_seg_y[0] + 5'd1;
      2'd2:    w_nx = r_seg_x[0] - 6'd1;
      default: w_nx = r_seg_x[0] + 6'd1;
    endcase
  end

  assign w_gp      = r_grow_pend | i_grow;
  assign w_chk_len = w_gp ? r_len : r_len - 5'd1;
  assign w_nh_wall = (w_nx == 6'd0) || (w_nx == 6'd39) || (w_ny == 5'd0) || (w_ny == 5'd29);
  assign w_nh_self = |w_chk_hit;

  assign w_cx = i_pos_x[9:4];
  assign w_cy = i_pos_y[9:4];
  assign w_unused_bits = ^{i_pos_x[3:0], i_pos_y[3:0]};
  assign w_pix_wall = (w_cx == 6'd0) || (w_cx == 6'd39) || (w_cy == 6'd0) || (w_cy == 6'd29);

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
    snake_seg_cmp u_cmp (
      .i_sx      (r_seg_x[g]),
      .i_sy      (r_seg_y[g]),
      .i_pix_vld (5'(g) < r_len),
      .i_chk_vld (5'(g) < w_chk_len),
      .i_px      (w_cx),
      .i_py      (w_cy),
      .i_nx      (w_nx),
      .i_ny      (w_ny),
      .o_pix_hit (w_pix_hit[g]),
      .o_chk_hit (w_chk_hit[g])
    );
  end

  // Lowest matching body index wins (descending scan, last write sticks).
  always_comb begin
    w_body_hit = 1'b0;
    w_body_idx = '0;
    w_body_dir = '0;
    for (int i = MAX_LEN - 1; i >= 1; i--) begin
      if (w_pix_hit[i]) begin
        w_body_hit = 1'b1;
        w_body_idx = 5'(i);
        w_body_dir = r_seg_dir[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_x <= L_INIT_X; r_seg_y <= L_INIT_Y; r_seg_dir <= L_INIT_D;
      r_len <= 5'(INIT_LEN); r_cur_dir <= INIT_DIR;
      r_grow_pend <= 1'b0; r_hit_wall <= 1'b0; r_hit_self <= 1'b0;
    end else if (w_do_init) begin
      r_seg_x <= L_INIT_X; r_seg_y <= L_INIT_Y; r_seg_dir <= L_INIT_D;
      r_len <= 5'(INIT_LEN); r_cur_dir <= INIT_DIR;
      r_grow_pend <= 1'b0; r_hit_wall <= 1'b0; r_hit_self <= 1'b0;
    end else begin
      if (i_grow) r_grow_pend <= 1'b1;
      if (w_do_move) begin
        r_cur_dir <= w_dir;
        if (w_nh_wall) r_hit_wall <= 1'b1;
        if (w_nh_self) r_hit_self <= 1'b1;
        if (!w_nh_wall && !w_nh_self) begin
          for (int i = 1; i < MAX_LEN; i++) begin
            r_seg_x[i]   <= r_seg_x[i-1];
            r_seg_y[i]   <= r_seg_y[i-1];
            r_seg_dir[i] <= r_seg_dir[i-1];
          end
          r_seg_x[0] <= w_nx; r_seg_y[0] <= w_ny; r_seg_dir[0] <= w_dir;
          if (w_gp) begin
            if (r_len < 5'(MAX_LEN)) r_len <= r_len + 5'd1;
            r_grow_pend <= 1'b0;
          end
        end
      end
    end
  end

  // One-cycle registered lookup to line up with the image ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_show <= 2'b00; r_img <= 4'h0;
    end else if (w_do_init) begin
      r_show <= 2'b00; r_img <= 4'h0;
    end else if (w_pix_hit[0]) begin
      r_show <= 2'b01; r_img <= {2'b00, r_cur_dir};
    end else if (w_body_hit) begin
      r_show <= 2'b10;
      r_img  <= (w_body_idx == r_len - 5'd1) ? {2'b01, w_body_dir} : {2'b10, w_body_dir};
    end else if (w_pix_wall) begin
      r_show <= 2'b11; r_img <= 4'h0;
    end else begin
      r_show <= 2'b00; r_img <= 4'h0;
    end
  end

  assign o_snake_show  = r_show;
  assign o_snake_image = r_img;
  assign o_head_x      = r_seg_x[0];
  assign o_head_y      = r_seg_y[0];
  assign o_length      = r_len;
  assign o_hit_wall    = r_hit_wall;
  assign o_hit_self    = r_hit_self;
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: queue-based snake model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_snake_body_engine;
  localparam int MAX_LEN = 16;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic [1:0] gs = 2'b00, dir = 2'd3;
  logic       tick = 1'b0, grow = 1'b0;
  logic [9:0] px = '0, py = '0;
  logic [1:0] o_snake_show;
  logic [3:0] o_snake_image;
  logic [5:0] o_head_x;
  logic [4:0] o_head_y, o_length;
  logic       o_hit_wall, o_hit_self;

  always #5 clk = ~clk;

  snake_body_engine dut (
    .clk(clk), .rst_n(rst_n), .i_game_status(gs), .i_move_tick(tick),
    .i_dir_in(dir), .i_grow(grow), .i_pos_x(px), .i_pos_y(py),
    .o_snake_show(o_snake_show), .o_snake_image(o_snake_image),
    .o_head_x(o_head_x), .o_head_y(o_head_y), .o_length(o_length),
    .o_hit_wall(o_hit_wall), .o_hit_self(o_hit_self)
  );

  typedef struct {int x; int y; int d;} seg_t;
  seg_t q[$];
  int m_cur, m_gp, m_wall, m_self, exp_show, exp_img;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task m_init();
    seg_t s;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      s.x = 10 - i; s.y = 10; s.d = 3;
      q.push_back(s);
    end
    m_cur = 3; m_gp = 0; m_wall = 0; m_self = 0; exp_show = 0; exp_img = 0;
  endtask

  // Model: snake is a queue, head at the front; a move pushes a new head and
  // drops the tail unless the snake is growing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || gs == 2'b00) m_init();
    else begin
      int cx, cy, hit, nx, ny, d, w, s, lim;
      seg_t ns;
      cx = int'(px[9:4]); cy = int'(py[9:4]);
      exp_show = 0; exp_img = 0; hit = 0;
      if (q[0].x == cx && q[0].y == cy) begin exp_show = 1; exp_img = m_cur; hit = 1; end
      for (int i = 1; i < q.size() && !hit; i++)
        if (q[i].x == cx && q[i].y == cy) begin
          exp_show = 2; hit = 1;
          exp_img = ((i == q.size() - 1) ? 4 : 8) + q[i].d;
        end
      if (!hit && (cx == 0 || cx == 39 || cy == 0 || cy == 29)) exp_show = 3;
      if (grow) m_gp = 1;
      if (gs == 2'b10 && !m_wall && !m_self && tick) begin
        d = (int'(dir) == (m_cur ^ 1)) ? m_cur : int'(dir);
        m_cur = d;
        nx = q[0].x + (d == 3 ? 1 : 0) - (d == 2 ? 1 : 0);
        ny = q[0].y + (d == 1 ? 1 : 0) - (d == 0 ? 1 : 0);
        w = (nx == 0 || nx == 39 || ny == 0 || ny == 29) ? 1 : 0;
        lim = m_gp ? q.size() : q.size() - 1;
        s = 0;
        for (int i = 0; i < lim; i++) if (q[i].x == nx && q[i].y == ny) s = 1;
        if (w) m_wall = 1;
        if (s) m_self = 1;
        if (!w && !s) begin
          ns.x = nx; ns.y = ny; ns.d = d;
          q.push_front(ns);
          if (m_gp) m_gp = 0; else void'(q.pop_back());
          if (q.size() > MAX_LEN) void'(q.pop_back());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && q.size() != 0) begin
      chk("cyc_show",  int'(o_snake_show),  exp_show);
      chk("cyc_image", int'(o_snake_image), exp_img);
      chk("cyc_head_x", int'(o_head_x), q[0].x);
      chk("cyc_head_y", int'(o_head_y), q[0].y);
      chk("cyc_length", int'(o_length), q.size());
      chk("cyc_hit_wall", int'(o_hit_wall), m_wall);
      chk("cyc_hit_self", int'(o_hit_self), m_self);
    end
  end

  task cyc(); @(negedge clk); endtask
  task mv();  tick = 1'b1; cyc(); tick = 1'b0; cyc(); endtask
  task mvg(); tick = 1'b1; grow = 1'b1; cyc(); tick = 1'b0; grow = 1'b0; cyc(); endtask
  task pix(input int x, input int y, input int show, input int img, input string nm);
    px = 10'(x); py = 10'(y); cyc();
    chk({nm, "_show"}, int'(o_snake_show), show);
    chk({nm, "_img"},  int'(o_snake_image), img);
  endtask
  task restart(); gs = 2'b00; cyc(); gs = 2'b10; cyc(); endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_head_x", int'(o_head_x), 10);
    chk("rst_length", int'(o_length), 3);
    chk("rst_show", int'(o_snake_show), 0);
    chk("rst_hit_wall", int'(o_hit_wall), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: restart shows nothing; initial body visible once out of RESTART
    px = 10'd160; py = 10'd160; cyc(); cyc();
    chk("init_show_blank", int'(o_snake_show), 0);
    gs = 2'b01; cyc();
    pix(160, 160, 1, 3, "t1_head");
    pix(144, 160, 2, 11, "t1_body");
    pix(128, 160, 2, 7, "t1_tail");
    pix(0, 0, 3, 0, "t1_wall");
    pix(400, 400, 0, 0, "t1_none");
    chk("t1_head_x", int'(o_head_x), 10);
    chk("t1_length", int'(o_length), 3);

    // 2: three moves right; DIE holds the snake
    gs = 2'b10; dir = 2'd3; cyc();
    repeat (3) mv();
    chk("t2_head_x", int'(o_head_x), 13);
    chk("t2_head_y", int'(o_head_y), 10);
    pix(160, 160, 0, 0, "t2_vacated");
    gs = 2'b11; cyc(); mv();
    chk("t2_die_hold", int'(o_head_x), 13);
    gs = 2'b10; cyc();

    // 3: reversal ignored, then turn up
    dir = 2'd2; mv();
    chk("t3_rev_x", int'(o_head_x), 14);
    dir = 2'd0; mv();
    chk("t3_up_y", int'(o_head_y), 9);
    chk("t3_up_x", int'(o_head_x), 14);
    pix(224, 144, 1, 0, "t3_head_up");

    // 4: grow consumed by the next move only; saturation at MAX_LEN
    grow = 1'b1; cyc(); grow = 1'b0;
    mv(); chk("t4_len_grow", int'(o_length), 4);
    mv(); chk("t4_len_keep", int'(o_length), 4);
    chk("t4_head_y", int'(o_head_y), 7);
    dir = 2'd3;
    repeat (12) mvg();
    chk("t4_len16", int'(o_length), 16);
    chk("t4_head_x", int'(o_head_x), 26);
    mvg();
    chk("t4_len_sat", int'(o_length), 16);
    chk("t4_head_x2", int'(o_head_x), 27);
    pix(224, 144, 2, 4, "t4_tail16");
    pix(224, 160, 0, 0, "t4_cut");

    // 5: wall hit freezes the snake until RESTART
    repeat (11) mv();
    chk("t5_head_x38", int'(o_head_x), 38);
    mv();
    chk("t5_hit_wall", int'(o_hit_wall), 1);
    chk("t5_head_stay", int'(o_head_x), 38);
    mv();
    chk("t5_ignored", int'(o_head_x), 38);
    chk("t5_no_self", int'(o_hit_self), 0);
    gs = 2'b00; cyc();
    chk("t5_clear", int'(o_hit_wall), 0);
    gs = 2'b01; cyc();
    chk("t5_head_x", int'(o_head_x), 10);
    chk("t5_length", int'(o_length), 3);
    pix(144, 160, 2, 11, "t5_restored");

    // reset mid-move aborts the move
    gs = 2'b10; cyc(); mv();
    tick = 1'b1; #2 rst_n = 1'b0; #1;
    chk("rst_mid_async", int'(o_head_x), 10);
    @(negedge clk); tick = 1'b0; rst_n = 1'b1;
    chk("rst_mid_hold", int'(o_head_x), 10);
    chk("rst_mid_len", int'(o_length), 3);

    // 6c: U-turn onto the tail cell without grow is legal
    restart(); dir = 2'd3; mvg();
    dir = 2'd0; mv(); dir = 2'd2; mv(); dir = 2'd1; mv();
    chk("t6c_no_self", int'(o_hit_self), 0);
    chk("t6c_head_x", int'(o_head_x), 10);
    chk("t6c_head_y", int'(o_head_y), 10);

    // 6b: same U-turn with grow pending hits the tail
    restart(); dir = 2'd3; mvg();
    dir = 2'd0; mv(); dir = 2'd2; mv();
    grow = 1'b1; cyc(); grow = 1'b0;
    dir = 2'd1; mv();
    chk("t6b_hit_self", int'(o_hit_self), 1);
    chk("t6b_head_x", int'(o_head_x), 10);
    chk("t6b_head_y", int'(o_head_y), 9);
    chk("t6b_length", int'(o_length), 4);

    // 6a: length 5 turning into its own body
    restart(); dir = 2'd3; mvg(); mvg();
    chk("t6a_len5", int'(o_length), 5);
    dir = 2'd0; mv(); dir = 2'd2; mv(); dir = 2'd1; mv();
    chk("t6a_hit_self", int'(o_hit_self), 1);
    chk("t6a_head_x", int'(o_head_x), 11);
    chk("t6a_head_y", int'(o_head_y), 9);
    chk("t6a_no_wall", int'(o_hit_wall), 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
